// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/sequencing controller with forwarding, memory-wait FSM and perf counters
module hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             startin,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          frozen, live, br, lu, jmp;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    return (mem_regwrite && |mem_rd && mem_rd == src) ? 2'b10 :
           (wb_regwrite && |wb_rd && wb_rd == src) ? 2'b01 : 2'b00;
  endfunction

  // a held MEM access keeps the whole pipe frozen until dmem_ready
  assign frozen = !dmem_ready && (state == MEM_WAIT || (state == RUN && mem_access));
  assign live   = startin && state != HALT && !frozen;
  assign br     = ex_branch_taken;
  assign lu     = !br && ex_memread && |ex_rd && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  assign jmp    = !br && !lu && id_jump;

  assign pc_we        = live && !lu;
  assign ifid_we      = live && !lu;
  assign idex_we      = live;
  assign exmem_we     = live;
  assign ifid_flush   = live && (br || jmp);
  assign idex_flush   = live && (br || lu);
  assign memwb_bubble = startin && (state == HALT || frozen);
  assign halted       = state == HALT;
  assign fwd_a        = startin ? fwd_sel(ex_rs) : 2'b00;
  assign fwd_b        = startin ? fwd_sel(ex_rt) : 2'b00;

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (state != HALT && !pc_we && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (ifid_flush && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
      if (state == RUN && frozen) begin
        state    <= MEM_WAIT;
        wait_cnt <= WW'(1);
      end else if (state == MEM_WAIT) begin
        if (dmem_ready) begin
          state    <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == WW'(WAIT_MAX)) state <= HALT;
        else wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB registers plus PC).
- Detects load-use hazards, branch/jump redirects and multi-cycle data-memory waits.
- Drives per-stage write-enable, flush and bubble controls, and the EX-stage forwarding selects.
- Holds a wait/timeout FSM and stall/flush performance counters.

Parameters:
WAIT_MAX, 15, max consecutive cycles a MEM-stage access may wait for dmem_ready before HALT
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock, rising edge
startin  in  1  reset, asynchronous, active-low
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_jump  in  1  jump decoded in ID
ex_rs  in  5  rs of instruction in EX
ex_rt  in  5  rt of instruction in EX
ex_rd  in  5  destination register of instruction in EX
ex_memread  in  1  EX instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX
mem_rd  in  5  destination in MEM
mem_regwrite  in  1  MEM instruction writes register
mem_access  in  1  MEM instruction is load/store
dmem_ready  in  1  data memory completes access this cycle
wb_rd  in  5  destination in WB
wb_regwrite  in  1  WB instruction writes register
pc_we  out  1  PC write enable
ifid_we  out  1  IF_ID write enable
ifid_flush  out  1  IF_ID loads NOP
idex_we  out  1  ID_EX write enable
idex_flush  out  1  ID_EX loads bubble (all controls 0)
exmem_we  out  1  EX_MEM write enable
memwb_bubble  out  1  MEM_WB loads bubble (regwrite/memtoreg/jump = 0)
fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX_MEM result, 01 MEM_WB result
fwd_b  out  2  ALU operand B select, same encoding
halted  out  1  sticky memory-timeout fault
stall_cycles  out  CNT_W  count of cycles with pc_we=0
flush_count  out  CNT_W  count of redirect flushes

Behaviour:
- State register: RUN, MEM_WAIT, HALT. startin=0 asynchronously forces RUN, wait_cnt=0, halted=0, both counters 0, regardless of current state (including mid-MEM_WAIT).
- While startin=0: all *_we=0, all flush/bubble=0, fwd_a=fwd_b=00.
- Outputs are combinational from state and inputs; state and counters are registered.
- Forwarding (all states), computed for ex_rs -> fwd_a and ex_rt -> fwd_b:
  - 10 if mem_regwrite and mem_rd!=0 and mem_rd==src.
  - else 01 if wb_regwrite and wb_rd!=0 and wb_rd==src.
  - else 00.
  - MEM has priority over WB.
- Defaults in RUN: pc_we=ifid_we=idex_we=exmem_we=1, flush/bubble=0.
- Memory wait (highest priority):
  - RUN with mem_access=1 and dmem_ready=0 gives a same-cycle freeze: pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, no flushes. Next state MEM_WAIT, wait_cnt=1.
  - MEM_WAIT with dmem_ready=0: freeze continues and wait_cnt increments.
  - If wait_cnt==WAIT_MAX and dmem_ready=0, next state is HALT.
  - MEM_WAIT with dmem_ready=1: RUN outputs apply this cycle (including pending redirect/load-use from held EX/ID contents). Next state RUN, wait_cnt=0.
  - Branch/jump/load-use inputs are ignored while frozen.
- HALT: all *_we=0, memwb_bubble=1, halted=1, counters frozen. Only reset exits.
- Redirects (RUN, not frozen):
  - ex_branch_taken=1 gives ifid_flush=1 and idex_flush=1.
  - Otherwise id_jump=1 gives ifid_flush=1 only.
  - Branch wins over a simultaneous jump or load-use.
  - pc_we stays 1.
- Load-use (RUN, not frozen, no taken branch):
  - Condition: ex_memread and ex_rd!=0 and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)).
  - Response: pc_we=0, ifid_we=0, idex_flush=1. This lasts exactly one cycle, because the load then leaves EX.
  - A simultaneous id_jump is suppressed that cycle and re-evaluated the next cycle.
- Counters:
  - stall_cycles increments on every cycle with startin=1, state!=HALT and pc_we=0.
  - flush_count increments on every cycle where ifid_flush=1.
  - Both saturate at all-ones (no wrap).

Test Plan:
- Reset: startin=0 then 1 with all inputs 0 -> first cycle pc_we=ifid_we=idex_we=exmem_we=1, fwd_a=fwd_b=00, counters 0, halted=0.
- Forwarding: ex_rs=5, ex_rt=5, mem_rd=5/mem_regwrite=1, wb_rd=5/wb_regwrite=1 -> fwd_a=fwd_b=10. Drop mem_regwrite -> 01. Set mem_rd=wb_rd=0 -> 00.
- Load-use: ex_memread=1, ex_rd=8, id_rs=8 -> one cycle pc_we=0, ifid_we=0, idex_flush=1, stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 together with the load-use condition and id_jump=1 -> ifid_flush=1, idex_flush=1, pc_we=1, flush_count+1.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with memwb_bubble=1, release on the 4th cycle, stall_cycles=3, state back to RUN.
- Timeout and reset: dmem_ready held 0 for WAIT_MAX+2 cycles -> HALT, halted=1, counters frozen. Assert startin=0 mid-HALT -> immediate RUN, halted=0, counters 0.
